dmem_arbiter: RTL
=================

# dmem_arbiter

Shares the single-port data memory (17-bit word address, 32-bit data) between two requesters: port 0 is the processor's data-memory port, port 1 is the game-side fetch engine that reads player/powerup/maze state for the VGA path. The block selects one requester per cycle with bounded round-robin fairness, drives the RAM port, and routes each read result back to its issuer with a fixed latency. It sits between `proc_skeleton` / VGA fetch logic and the dmem RAM instance in the top level.

## Interface
- `ADDR_W`, 17, word address width
- `DATA_W`, 32, data width
- `RD_LAT`, 1, RAM read latency in cycles, legal 1..4
- `MAX_BURST`, 4, max consecutive grants to one port while the other is waiting, legal 1..15

- `clock` in 1: sole clock, all state on rising edge
- `reset` in 1: synchronous, active-high
- `req0`, `req1` in 1: request valid, held until granted
- `we0`, `we1` in 1: 1 = write, 0 = read
- `addr0`, `addr1` in ADDR_W: word address
- `wdata0`, `wdata1` in DATA_W: write data
- `gnt0`, `gnt1` out 1: combinational grant; access accepted when `reqN && gntN`
- `rvalid0`, `rvalid1` out 1: read data valid, one-cycle pulse
- `rdata0`, `rdata1` out DATA_W: read data, equal to `ram_q` (valid only with `rvalidN`)
- `ram_addr` out ADDR_W, `ram_wdata` out DATA_W, `ram_wren` out 1: RAM port
- `ram_q` in DATA_W: RAM read data, valid RD_LAT cycles after address presented

## Operation
- State: `owner` (OWN0/OWN1, last granted port), `burst` counter (0..MAX_BURST, saturating).
- Grant rule, evaluated each cycle (at most one of `gnt0`/`gnt1` high):
  - neither requesting: no grant; `burst` <= 0; `owner` unchanged.
  - only port N requesting: grant N.
  - both requesting: grant `owner` if `burst < MAX_BURST`, else grant the other port.
- On accept by port N: if N == `owner`, `burst` <= min(`burst`+1, MAX_BURST); else `owner` <= N, `burst` <= 1.
- RAM drive: `ram_addr`/`ram_wdata` = granted port's address/data; `ram_wren` = accepted write; with no grant, `ram_addr` = 0, `ram_wdata` = 0, `ram_wren` = 0.
- Read return: a tag pipeline of RD_LAT stages carries {valid, port}; an accepted read enters stage 0; at the last stage `rvalidN` pulses for the tagged port. Writes push an invalid tag. `rdata0` and `rdata1` are both wired to `ram_q`.
- Same-address write then read (any ports, consecutive cycles): the read returns the written value (RAM is write-first; the arbiter adds no bypass).

## Timing
- Reset values: `owner` = OWN0, `burst` = 0, all tag stages invalid, so `rvalid0` = `rvalid1` = 0. While `reset` is high, `gnt0` = `gnt1` = 0 and `ram_wren` = 0.
- Grant latency: 0 cycles (combinational from `req*` and state).
- Read latency: `rvalidN` is high exactly RD_LAT cycles after the accepting edge; one return per accepted read; returns stay in issue order.
- Throughput: one access per cycle; back-to-back reads from either port are allowed.
- Reset mid-operation: in-flight tags are cleared and their `rvalid` never asserts. `owner` and `burst` return to reset values.
- Starvation bound: a waiting port is granted within MAX_BURST cycles of its `req` rising.

## Structure
- Package `dmem_arb_pkg`: default ADDR_W/DATA_W/RD_LAT/MAX_BURST and the `owner_t` enum (OWN0, OWN1).
- Sub-module `rd_tag_pipe`: RD_LAT-deep shift register of {valid, port}, with synchronous clear. The arbiter FSM and muxing stay in the top module.

## Test plan
- Reset then `req0` read addr 0x00010 (RAM holds 0xDEADBEEF), RD_LAT=1 -> `gnt0`=1 same cycle, `rvalid0`=1 with `rdata0`=0xDEADBEEF one cycle later, `rvalid1` stays 0.
- Both ports request reads continuously, MAX_BURST=4, after reset -> grant pattern 0,0,0,0,1,1,1,1,0… and every `rvalid` tag matches its issuer.
- `req1` alone writes 0x12345678 to 0x00100, then `req0` reads 0x00100 -> `ram_wren`=1 for one cycle, no `rvalid1`, `rdata0`=0x12345678.
- RD_LAT=3, port 0 issues reads at cycles 5, 6, 7 -> `rvalid0` high at cycles 8, 9, 10.
- Port 1 issues a read, then `reset` pulses the next cycle, RD_LAT=2 -> no `rvalid1`, `owner`=OWN0 and `burst`=0 afterwards.
- One idle cycle (no requests) inserted mid-burst after 3 port-0 grants -> `burst` clears to 0, so port 0 gets 4 further consecutive grants before port 1.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared defaults and types for the data-memory arbiter slice.
package dmem_arb_pkg;

  localparam int DMEM_ADDR_W    = 17;
  localparam int DMEM_DATA_W    = 32;
  localparam int DMEM_RD_LAT    = 1;
  localparam int DMEM_MAX_BURST = 4;

  typedef enum logic {
    OWN0 = 1'b0,
    OWN1 = 1'b1
  } owner_t;

  // Wide enough for MAX_BURST up to 15.
  typedef logic [3:0] burst_t;

  function automatic owner_t other_port(input owner_t o);
    return (o == OWN0) ? OWN1 : OWN0;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rd_tag_pipe.sv
// Read-return tag pipeline: DEPTH-stage shift register of {valid, port}.
module rd_tag_pipe
  import dmem_arb_pkg::*;
#(
  parameter int DEPTH = DMEM_RD_LAT
) (
  input  logic clk_i,
  input  logic clr_i,
  input  logic valid_i,
  input  logic port_i,
  output logic valid_o,
  output logic port_o
);

  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] port_q;

  // Shift tags one stage per cycle; clear drops every in-flight tag.
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      valid_q <= {DEPTH{1'b0}};
      port_q  <= {DEPTH{1'b0}};
    end else begin
      valid_q[0] <= valid_i;
      port_q[0]  <= port_i;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        port_q[i]  <= port_q[i-1];
      end
    end
  end

  assign valid_o = valid_q[DEPTH-1];
  assign port_o  = port_q[DEPTH-1];

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter for the single-port dmem RAM with bounded
// bursts and fixed-latency read return routing.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W    = DMEM_ADDR_W,
  parameter int DATA_W    = DMEM_DATA_W,
  parameter int RD_LAT    = DMEM_RD_LAT,
  parameter int MAX_BURST = DMEM_MAX_BURST
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q
);

  localparam burst_t BURST_MAX = burst_t'(MAX_BURST);

  owner_t owner_q, owner_d;
  burst_t burst_q, burst_d;
  owner_t acc_port_s;
  logic   gnt0_s, gnt1_s;
  logic   rd_acc_s;
  logic   tag_valid_s, tag_port_s;

  // Arbitration state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      owner_q <= OWN0;
      burst_q <= 4'd0;
    end else begin
      owner_q <= owner_d;
      burst_q <= burst_d;
    end
  end

  // Grant selection; the owner keeps the port until its burst is spent.
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (reset) begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end else if (req0 && req1) begin
      if (burst_q < BURST_MAX) begin
        gnt0_s = (owner_q == OWN0);
        gnt1_s = (owner_q == OWN1);
      end else begin
        gnt0_s = (other_port(owner_q) == OWN0);
        gnt1_s = (other_port(owner_q) == OWN1);
      end
    end else begin
      gnt0_s = req0;
      gnt1_s = req1;
    end
  end

  assign acc_port_s = gnt1_s ? OWN1 : OWN0;

  // Owner/burst update on each accepted access or idle cycle.
  always_comb begin
    owner_d = owner_q;
    burst_d = burst_q;
    if (!req0 && !req1) begin
      burst_d = 4'd0;
    end else if (gnt0_s || gnt1_s) begin
      if (acc_port_s == owner_q) begin
        if (burst_q < BURST_MAX) begin
          burst_d = burst_q + 4'd1;
        end else begin
          burst_d = BURST_MAX;
        end
      end else begin
        owner_d = acc_port_s;
        burst_d = 4'd1;
      end
    end else begin
      owner_d = owner_q;
      burst_d = burst_q;
    end
  end

  // RAM port mux; idle cycles drive zeros.
  always_comb begin
    ram_addr  = {ADDR_W{1'b0}};
    ram_wdata = {DATA_W{1'b0}};
    ram_wren  = 1'b0;
    rd_acc_s  = 1'b0;
    if (gnt0_s) begin
      ram_addr  = addr0;
      ram_wdata = wdata0;
      ram_wren  = we0;
      rd_acc_s  = ~we0;
    end else if (gnt1_s) begin
      ram_addr  = addr1;
      ram_wdata = wdata1;
      ram_wren  = we1;
      rd_acc_s  = ~we1;
    end else begin
      ram_addr  = {ADDR_W{1'b0}};
      ram_wdata = {DATA_W{1'b0}};
      ram_wren  = 1'b0;
      rd_acc_s  = 1'b0;
    end
  end

  rd_tag_pipe #(
    .DEPTH (RD_LAT)
  ) u_rd_tag_pipe (
    .clk_i   (clock),
    .clr_i   (reset),
    .valid_i (rd_acc_s),
    .port_i  (gnt1_s),
    .valid_o (tag_valid_s),
    .port_o  (tag_port_s)
  );

  assign gnt0    = gnt0_s;
  assign gnt1    = gnt1_s;
  assign rvalid0 = tag_valid_s & ~tag_port_s;
  assign rvalid1 = tag_valid_s & tag_port_s;
  assign rdata0  = ram_q;
  assign rdata1  = ram_q;

endmodule
